// File: rtl/tone_pkg.sv
// Shared definitions for the tone sequencer: tone codes, register map,
// FSM encoding and request-priority helpers.
package tone_pkg;

  localparam logic [1:0] TONE_OFF = 2'd0;
  localparam logic [1:0] PADDLE   = 2'd1;
  localparam logic [1:0] WALL     = 2'd2;
  localparam logic [1:0] SCORE    = 2'd3;

  localparam logic [1:0] ADDR_STATUS   = 2'd0;
  localparam logic [1:0] ADDR_DURATION = 2'd1;
  localparam logic [1:0] ADDR_SW_REQ   = 2'd2;
  localparam logic [1:0] ADDR_CTRL     = 2'd3;

  // Bit positions inside the 4-bit pending vector {sw, score, wall, paddle}
  localparam int SRC_PADDLE = 0;
  localparam int SRC_WALL   = 1;
  localparam int SRC_SCORE  = 2;
  localparam int SRC_SW     = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_t;

  // One-hot winner among pending requests: score > wall > paddle > sw
  function automatic logic [3:0] pick_winner(input logic [3:0] pend);
    if (pend[SRC_SCORE])       return 4'b0100;
    else if (pend[SRC_WALL])   return 4'b0010;
    else if (pend[SRC_PADDLE]) return 4'b0001;
    else if (pend[SRC_SW])     return 4'b1000;
    else                       return 4'b0000;
  endfunction

  function automatic logic [1:0] src_rank(input logic [3:0] onehot);
    if (onehot[SRC_SCORE])       return 2'd3;
    else if (onehot[SRC_WALL])   return 2'd2;
    else if (onehot[SRC_PADDLE]) return 2'd1;
    else                         return 2'd0;
  endfunction

endpackage

// File: rtl/tone_sequencer_if.sv
// Avalon-MM slave bus seen by the tone sequencer register block.
interface tone_sequencer_if;
  import tone_pkg::*;

  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/tick_prescaler.sv
// Free-running divider producing a one-cycle tick every TICK_DIV clocks;
// i_clr restarts the count so a new tone gets whole ticks.
module tick_prescaler
  import tone_pkg::*;
#(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_clr,
  output logic o_tick
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n || i_clr) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + PW'(1);
    end
  end

  assign o_tick = (r_cnt == LAST);
endmodule

// File: rtl/tone_sequencer.sv
// Avalon-MM tone sequencer: latches game/software tone requests, plays them by
// fixed priority with a silent gap. TONE_SEQ_PREEMPT_EN enables preemption.
module tone_sequencer
  import tone_pkg::*;
#(
  parameter int TICK_DIV  = 50000,
  parameter int DUR_W     = 10,
  parameter int GAP_TICKS = 20,
  parameter int DUR_RESET = 100
) (
  input  logic             clk,
  input  logic             reset_n,
  tone_sequencer_if.slave  avs,
  input  logic             ev_paddle,
  input  logic             ev_wall,
  input  logic             ev_score,
  output logic [1:0]       out_port,
  output logic             busy
);
  localparam int GAP_W = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
  localparam int CNT_W = (DUR_W > GAP_W) ? DUR_W : GAP_W;

  state_t           r_state, w_state_next;
  logic [1:0]       r_out, w_out_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic [3:0]       r_pending;
  logic [1:0]       r_sw_code;
  logic [DUR_W-1:0] r_duration;
  logic             r_enable, r_missed;

  logic             w_tick, w_start, w_preempt, w_any;
  logic             w_wr, w_sw_wr, w_ctrl_wr, w_unused;
  logic [3:0]       w_ev, w_win;
  logic [1:0]       w_win_code;
  logic [CNT_W-1:0] w_dur_load;

  assign w_wr      = avs.chipselect && !avs.write_n;
  assign w_ctrl_wr = w_wr && (avs.address == ADDR_CTRL);
  assign w_sw_wr   = w_wr && (avs.address == ADDR_SW_REQ) && (avs.writedata[1:0] != TONE_OFF);
  assign w_ev      = r_enable ? {w_sw_wr, ev_score, ev_wall, ev_paddle} : 4'b0000;
  assign w_any     = |r_pending;
  assign w_win     = pick_winner(r_pending);
  assign w_dur_load = (r_duration == '0) ? CNT_W'(1) : CNT_W'(r_duration);
  assign w_unused  = &{1'b0, avs.writedata[31:DUR_W]};

  always_comb begin
    w_win_code = TONE_OFF;
    case (w_win)
      4'b0100: w_win_code = SCORE;
      4'b0010: w_win_code = WALL;
      4'b0001: w_win_code = PADDLE;
      4'b1000: w_win_code = r_sw_code;
      default: w_win_code = TONE_OFF;
    endcase
  end

`ifdef TONE_SEQ_PREEMPT_EN
  logic [1:0] r_rank;

  // Any request beats the gap; during a tone only a strictly higher source does
  assign w_preempt = w_any && ((r_state == GAP) ||
                               ((r_state == PLAY) && (src_rank(w_win) > r_rank)));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rank <= 2'd0;
    end else if (w_start) begin
      r_rank <= src_rank(w_win);
    end
  end
`else
  assign w_preempt = 1'b0;
`endif

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clr   (w_start),
    .o_tick  (w_tick)
  );

  always_comb begin
    w_state_next = r_state;
    w_out_next   = r_out;
    w_cnt_next   = r_cnt;
    w_start      = 1'b0;
    case (r_state)
      IDLE: w_start = w_any;
      PLAY: begin
        if (w_tick) begin
          if (r_cnt == CNT_W'(1)) begin
            w_state_next = GAP;
            w_out_next   = TONE_OFF;
            w_cnt_next   = CNT_W'(GAP_TICKS);
          end else begin
            w_cnt_next = r_cnt - CNT_W'(1);
          end
        end
      end
      GAP: begin
        // A zero-length gap leaves after a single cycle
        if (r_cnt == '0) begin
          w_state_next = IDLE;
        end else if (w_tick) begin
          if (r_cnt == CNT_W'(1)) w_state_next = IDLE;
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      default: w_state_next = IDLE;
    endcase
    if (w_preempt) w_start = 1'b1;
    if (w_start) begin
      w_state_next = PLAY;
      w_out_next   = w_win_code;
      w_cnt_next   = w_dur_load;
    end
    if (!r_enable) begin
      w_state_next = IDLE;
      w_out_next   = TONE_OFF;
      w_cnt_next   = '0;
      w_start      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_out      <= TONE_OFF;
      r_cnt      <= '0;
      r_pending  <= 4'b0000;
      r_sw_code  <= TONE_OFF;
      r_duration <= DUR_W'(DUR_RESET);
      r_enable   <= 1'b1;
      r_missed   <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_out     <= w_out_next;
      r_cnt     <= w_cnt_next;
      r_pending <= r_enable ? ((r_pending | w_ev) & ~(w_start ? w_win : 4'b0000)) : 4'b0000;
      if (w_ev[SRC_SW] && !r_pending[SRC_SW]) r_sw_code <= avs.writedata[1:0];
      if (|(w_ev & r_pending)) begin
        r_missed <= 1'b1;
      end else if (w_ctrl_wr && avs.writedata[1]) begin
        r_missed <= 1'b0;
      end
      if (w_ctrl_wr) r_enable <= avs.writedata[0];
      if (w_wr && (avs.address == ADDR_DURATION)) r_duration <= avs.writedata[DUR_W-1:0];
    end
  end

  always_comb begin
    avs.readdata = 32'd0;
    case (avs.address)
      ADDR_STATUS:   avs.readdata = {19'd0, r_pending, busy, 6'd0, r_out};
      ADDR_DURATION: avs.readdata = 32'(r_duration);
      ADDR_CTRL:     avs.readdata = {30'd0, r_missed, r_enable};
      default:       avs.readdata = 32'd0;
    endcase
  end

  assign out_port = r_out;
  assign busy     = (r_state != IDLE);
endmodule

// File: tb/tb_tone_sequencer.sv
// Bench for tone_sequencer: register table plus scoreboarded tone sequences
// (TICK_DIV=4, GAP_TICKS=2, DURATION=3 -> 12-cycle tone, 8-cycle gap).
module tb_tone_sequencer;
  import tone_pkg::*;

  logic       clk;
  logic       reset_n;
  logic       ev_paddle, ev_wall, ev_score;
  logic [1:0] out_port;
  logic       busy;

  tone_sequencer_if bus ();

  tone_sequencer #(
    .TICK_DIV  (4),
    .DUR_W     (10),
    .GAP_TICKS (2),
    .DUR_RESET (100)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .avs       (bus),
    .ev_paddle (ev_paddle),
    .ev_wall   (ev_wall),
    .ev_score  (ev_score),
    .out_port  (out_port),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] code;
    int         len;
  } tone_t;

  typedef struct {
    bit          wr;
    logic [1:0]  addr;
    logic [31:0] data;
    string       name;
  } reg_vec_t;

  tone_t exp_tone_q[$];
  tone_t obs_tone_q[$];
  int    exp_busy_q[$];
  int    obs_busy_q[$];

  int n_cmp = 0;
  int n_err = 0;

  // Monitor: records each completed tone (code, length) and each busy run
  logic [1:0] mon_code = 2'd0;
  int         mon_len  = 0;
  int         busy_len = 0;
  always @(negedge clk) begin
    if (out_port != mon_code) begin
      if (mon_code != 2'd0) begin
        tone_t t;
        t.code = mon_code;
        t.len  = mon_len;
        obs_tone_q.push_back(t);
      end
      mon_code = out_port;
      mon_len  = 1;
    end else begin
      mon_len = mon_len + 1;
    end
    if (busy) begin
      busy_len = busy_len + 1;
    end else if (busy_len != 0) begin
      obs_busy_q.push_back(busy_len);
      busy_len = 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_tone(input logic [1:0] code, input int len);
    tone_t t;
    t.code = code;
    t.len  = len;
    exp_tone_q.push_back(t);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.writedata  = d;
    @(posedge clk);
    #1;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    $display("bus write addr=%0d data=0x%0h", a, d);
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(posedge clk);
    #1;
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    @(negedge clk);
    d = bus.readdata;
    bus.chipselect = 1'b0;
    $display("bus read  addr=%0d data=0x%0h", a, d);
  endtask

  task automatic read_check(input string name, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    bus_read(a, rd);
    check(name, rd, exp);
  endtask

  task automatic pulse(input logic p, input logic w, input logic s);
    @(posedge clk);
    #1;
    ev_paddle = p;
    ev_wall   = w;
    ev_score  = s;
    @(posedge clk);
    #1;
    ev_paddle = 1'b0;
    ev_wall   = 1'b0;
    ev_score  = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int quiet = 0;
    int n = 0;
    while (quiet < 4 && n < 400) begin
      @(negedge clk);
      n++;
      if (busy === 1'b0 && out_port === 2'd0) quiet++;
      else quiet = 0;
    end
    n_cmp++;
    if (quiet < 4) begin
      n_err++;
      $display("FAIL %s_idle: quiet cycles %0d after timeout, expected 4", name, quiet);
    end
  endtask

  task automatic sb_check(input string name);
    tone_t te, to;
    int be, bo;
    while (exp_tone_q.size() > 0) begin
      te = exp_tone_q.pop_front();
      if (obs_tone_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL %s_tone: got no tone, expected code %0d len %0d", name, te.code, te.len);
      end else begin
        to = obs_tone_q.pop_front();
        $display("tone %s: code=%0d len=%0d (exp code=%0d len=%0d)", name, to.code, to.len, te.code, te.len);
        check({name, "_code"}, 32'(to.code), 32'(te.code));
        check({name, "_len"}, 32'(to.len), 32'(te.len));
      end
    end
    check({name, "_extra_tones"}, 32'(obs_tone_q.size()), 32'd0);
    obs_tone_q.delete();
    while (exp_busy_q.size() > 0) begin
      be = exp_busy_q.pop_front();
      if (obs_busy_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL %s_busy: got no busy run, expected %0d cycles", name, be);
      end else begin
        bo = obs_busy_q.pop_front();
        check({name, "_busy_len"}, 32'(bo), 32'(be));
      end
    end
    check({name, "_extra_busy"}, 32'(obs_busy_q.size()), 32'd0);
    obs_busy_q.delete();
  endtask

  reg_vec_t vecs[12];

  initial begin
    vecs[0]  = '{1'b0, ADDR_STATUS,   32'h0000_0000, "rst_status"};
    vecs[1]  = '{1'b0, ADDR_DURATION, 32'd100,       "rst_duration"};
    vecs[2]  = '{1'b0, ADDR_SW_REQ,   32'h0000_0000, "rst_swreq"};
    vecs[3]  = '{1'b0, ADDR_CTRL,     32'h0000_0001, "rst_ctrl"};
    vecs[4]  = '{1'b1, ADDR_DURATION, 32'hFFFF_FFFF, "wr_dur_all"};
    vecs[5]  = '{1'b0, ADDR_DURATION, 32'h0000_03FF, "dur_mask"};
    vecs[6]  = '{1'b1, ADDR_CTRL,     32'hFFFF_FFFD, "wr_ctrl"};
    vecs[7]  = '{1'b0, ADDR_CTRL,     32'h0000_0001, "ctrl_unused"};
    vecs[8]  = '{1'b1, ADDR_DURATION, 32'd3,         "wr_dur3"};
    vecs[9]  = '{1'b0, ADDR_DURATION, 32'd3,         "dur3"};
    vecs[10] = '{1'b1, ADDR_SW_REQ,   32'd0,         "wr_sw_zero"};
    vecs[11] = '{1'b0, ADDR_STATUS,   32'h0000_0000, "sw_zero_ignored"};

    reset_n        = 1'b0;
    ev_paddle      = 1'b0;
    ev_wall        = 1'b0;
    ev_score       = 1'b0;
    bus.address    = 2'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = 32'd0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_port", 32'(out_port), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    obs_tone_q.delete();
    obs_busy_q.delete();

    // Register access table
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].data);
      else read_check(vecs[i].name, vecs[i].addr, vecs[i].data);
    end

    // Single paddle tone and one-edge latency
    pulse(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("paddle_lat_out0", 32'(out_port), 32'd0);
    @(negedge clk);
    check("paddle_lat_out1", 32'(out_port), 32'd1);
    check("paddle_lat_busy", 32'(busy), 32'd1);
    push_tone(PADDLE, 12);
    exp_busy_q.push_back(20);
    wait_idle("paddle");
    sb_check("paddle");

    // Simultaneous paddle and score: score first
    pulse(1'b1, 1'b0, 1'b1);
    push_tone(SCORE, 12);
    push_tone(PADDLE, 12);
    exp_busy_q.push_back(20);
    exp_busy_q.push_back(20);
    wait_idle("prio");
    sb_check("prio");

    // Duplicate wall while pending sets MISSED; W1C clears it
    pulse(1'b1, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    read_check("missed_set", ADDR_CTRL, 32'h3);
    bus_write(ADDR_CTRL, 32'h3);
    read_check("missed_clr", ADDR_CTRL, 32'h1);
    push_tone(PADDLE, 12);
    push_tone(WALL, 12);
    exp_busy_q.push_back(20);
    exp_busy_q.push_back(20);
    wait_idle("missed");
    sb_check("missed");

    // Software request, mid-tone DURATION change hits only the next tone
    bus_write(ADDR_SW_REQ, 32'd2);
    @(negedge clk);
    check("sw_lat_out0", 32'(out_port), 32'd0);
    @(negedge clk);
    check("sw_lat_out2", 32'(out_port), 32'd2);
    bus_write(ADDR_DURATION, 32'd5);
    pulse(1'b1, 1'b0, 1'b0);
    push_tone(WALL, 12);
    push_tone(PADDLE, 20);
    exp_busy_q.push_back(20);
    exp_busy_q.push_back(28);
    wait_idle("sw_dur");
    sb_check("sw_dur");
    bus_write(ADDR_DURATION, 32'd3);

    // ENABLE cleared mid-tone with paddle pending
    pulse(1'b0, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    pulse(1'b1, 1'b0, 1'b0);
    bus_write(ADDR_CTRL, 32'h0);
    @(negedge clk);
    @(negedge clk);
    check("dis_out_port", 32'(out_port), 32'd0);
    check("dis_busy", 32'(busy), 32'd0);
    read_check("dis_status", ADDR_STATUS, 32'h0);
    pulse(1'b0, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    check("dis_ev_ignored_out", 32'(out_port), 32'd0);
    read_check("dis_ev_status", ADDR_STATUS, 32'h0);
    read_check("dis_ctrl", ADDR_CTRL, 32'h0);
    bus_write(ADDR_CTRL, 32'h1);
    repeat (10) @(negedge clk);
    check("reen_out_port", 32'(out_port), 32'd0);
    push_tone(WALL, 6);
    exp_busy_q.push_back(6);
    sb_check("disable");

    // Reset mid-tone with wall pending
    pulse(1'b1, 1'b0, 1'b0);
    @(posedge clk);
    pulse(1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("midrst_out_port", 32'(out_port), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    read_check("midrst_duration", ADDR_DURATION, 32'd100);
    read_check("midrst_ctrl", ADDR_CTRL, 32'h1);
    push_tone(PADDLE, 4);
    exp_busy_q.push_back(4);
    wait_idle("midrst");
    sb_check("midrst");
    bus_write(ADDR_DURATION, 32'd3);

    // Score arriving during a paddle tone
    pulse(1'b1, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    pulse(1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("hi_prio_out_before", 32'(out_port), 32'd1);
`ifdef TONE_SEQ_PREEMPT_EN
    @(negedge clk);
    check("preempt_out", 32'(out_port), 32'd3);
    push_tone(PADDLE, 5);
    push_tone(SCORE, 12);
    exp_busy_q.push_back(25);
`else
    @(negedge clk);
    check("no_preempt_out", 32'(out_port), 32'd1);
    push_tone(PADDLE, 12);
    push_tone(SCORE, 12);
    exp_busy_q.push_back(20);
    exp_busy_q.push_back(20);
`endif
    wait_idle("hi_prio");
    sb_check("hi_prio");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time 200000 reached, expected earlier finish");
    $fatal(1, "watchdog");
  end
endmodule
